// File: rtl/slurm16_cpu_writeback_ctrl.sv
// slurm16_cpu_writeback_ctrl
// Pipeline stage 5 writeback controller. It picks the result source for each
// request (ALU, link, memory load, port read) and keeps destinations of
// outstanding loads in an in-order queue. Loads complete out-of-band through
// the mem/port response strobes. It grants one register-file write per cycle
// and uses a one-entry skid buffer to hold an ALU/LINK result that lost
// arbitration.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   wb_valid/src/reg/data    writeback request from stage 4
//   wb_stall                 request not accepted this cycle (combinational)
//   mem_rsp_valid/data       memory load response
//   port_rsp_valid/data      port read response
//   reg_wr_en/sel, reg_out   registered register-file write
//   pending_mask             one bit per register targeted by a queued load
//   rsp_err                  sticky protocol-error flag
//   bypass_valid/sel/data    next-cycle write preview
//
// Build option: define SLURM16_WB_BYPASS_EN to drive bypass_* with the write
// selected this cycle. Otherwise the bypass_* outputs are tied to 0.
module slurm16_cpu_writeback_ctrl #(
  parameter int REGISTER_BITS    = 4,
  parameter int BITS             = 16,
  parameter int LOAD_QUEUE_DEPTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        wb_valid,
  input  logic [1:0]                  wb_src,
  input  logic [REGISTER_BITS-1:0]    wb_reg,
  input  logic [BITS-1:0]             wb_data,
  output logic                        wb_stall,
  input  logic                        mem_rsp_valid,
  input  logic [BITS-1:0]             mem_rsp_data,
  input  logic                        port_rsp_valid,
  input  logic [BITS-1:0]             port_rsp_data,
  output logic                        reg_wr_en,
  output logic [REGISTER_BITS-1:0]    reg_wr_sel,
  output logic [BITS-1:0]             reg_out,
  output logic [2**REGISTER_BITS-1:0] pending_mask,
  output logic                        rsp_err,
  output logic                        bypass_valid,
  output logic [REGISTER_BITS-1:0]    bypass_sel,
  output logic [BITS-1:0]             bypass_data
);

  localparam int PW = $clog2(LOAD_QUEUE_DEPTH);

  // Queue entry: destination register plus source type (1 = port, 0 = memory).
  logic [REGISTER_BITS-1:0] q_reg  [LOAD_QUEUE_DEPTH];
  logic                     q_port [LOAD_QUEUE_DEPTH];
  // Pointers carry one extra bit so that full and empty can be told apart.
  logic [PW:0]              wr_ptr, rd_ptr, q_count;
  logic                     q_empty, q_full;

  logic                     skid_full;
  logic [REGISTER_BITS-1:0] skid_reg;
  logic [BITS-1:0]          skid_data;

  logic                     accept, is_load, push, rsp_ok, rsp_bad, skid_load;
  logic                     sel_valid;
  logic [REGISTER_BITS-1:0] sel_reg;
  logic [BITS-1:0]          sel_data;
  logic [PW:0]              ent_ptr;

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign q_count = wr_ptr - rd_ptr;

  assign is_load  = wb_src[1];
  // The full-queue stall ignores a same-cycle pop on purpose. This keeps the
  // stall off the response path.
  assign wb_stall = skid_full || (is_load && q_full);
  assign accept   = wb_valid && !wb_stall;
  assign push     = accept && is_load;

  always_comb begin
    rsp_ok = 1'b0;
    if (!q_empty && !(mem_rsp_valid && port_rsp_valid)) begin
      rsp_ok = q_port[rd_ptr[PW-1:0]] ? port_rsp_valid : mem_rsp_valid;
    end
  end

  assign rsp_bad   = (mem_rsp_valid || port_rsp_valid) && !rsp_ok;
  // ALU/LINK can only be accepted with the skid empty. So a colliding
  // response is the only thing that sends it to the skid.
  assign skid_load = accept && !is_load && rsp_ok;

  always_comb begin
    sel_valid = 1'b0;
    sel_reg   = '0;
    sel_data  = '0;
    if (rsp_ok) begin
      sel_valid = 1'b1;
      sel_reg   = q_reg[rd_ptr[PW-1:0]];
      sel_data  = mem_rsp_valid ? mem_rsp_data : port_rsp_data;
    end else if (skid_full) begin
      sel_valid = 1'b1;
      sel_reg   = skid_reg;
      sel_data  = skid_data;
    end else if (accept && !is_load) begin
      sel_valid = 1'b1;
      sel_reg   = wb_reg;
      sel_data  = wb_data;
    end
  end

  always_comb begin
    pending_mask = '0;
    ent_ptr      = '0;
    for (int i = 0; i < LOAD_QUEUE_DEPTH; i++) begin
      ent_ptr = rd_ptr + (PW+1)'(i);
      if ((PW+1)'(i) < q_count) begin
        pending_mask[q_reg[ent_ptr[PW-1:0]]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_reg[wr_ptr[PW-1:0]]  <= wb_reg;
      q_port[wr_ptr[PW-1:0]] <= wb_src[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      skid_full  <= 1'b0;
      skid_reg   <= '0;
      skid_data  <= '0;
      reg_wr_en  <= 1'b0;
      reg_wr_sel <= '0;
      reg_out    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rsp_ok) rd_ptr <= rd_ptr + 1'b1;
      if (rsp_bad) rsp_err <= 1'b1;
      if (skid_load) begin
        skid_full <= 1'b1;
        skid_reg  <= wb_reg;
        skid_data <= wb_data;
      end else if (skid_full && !rsp_ok) begin
        skid_full <= 1'b0;
      end
      // An r0 write still uses its slot, but it never strobes the register file.
      reg_wr_en <= sel_valid && (sel_reg != '0);
      if (sel_valid) begin
        reg_wr_sel <= sel_reg;
        reg_out    <= sel_data;
      end
    end
  end

`ifdef SLURM16_WB_BYPASS_EN
  assign bypass_valid = sel_valid && (sel_reg != '0);
  assign bypass_sel   = sel_reg;
  assign bypass_data  = sel_data;
`else
  assign bypass_valid = 1'b0;
  assign bypass_sel   = '0;
  assign bypass_data  = '0;
`endif

endmodule

// File: tb/tb_slurm16_cpu_writeback_ctrl.sv
module tb_slurm16_cpu_writeback_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [1:0]  wb_src;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        wb_stall;
  logic        mem_rsp_valid;
  logic [15:0] mem_rsp_data;
  logic        port_rsp_valid;
  logic [15:0] port_rsp_data;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_sel;
  logic [15:0] reg_out;
  logic [15:0] pending_mask;
  logic        rsp_err;
  logic        bypass_valid;
  logic [3:0]  bypass_sel;
  logic [15:0] bypass_data;

  int checks = 0;
  int failures = 0;

  slurm16_cpu_writeback_ctrl #(.REGISTER_BITS(4), .BITS(16), .LOAD_QUEUE_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst),
    .wb_valid(wb_valid), .wb_src(wb_src), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_stall(wb_stall),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .port_rsp_valid(port_rsp_valid), .port_rsp_data(port_rsp_data),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_out(reg_out),
    .pending_mask(pending_mask), .rsp_err(rsp_err),
    .bypass_valid(bypass_valid), .bypass_sel(bypass_sel), .bypass_data(bypass_data)
  );

  always #5 clk = ~clk;

  // Reference model: load queue as a list of {dest, is_port}, plus a skid slot.
  logic [3:0]  mq_reg[$];
  bit          mq_port[$];
  bit          ms_v;
  logic [3:0]  ms_reg;
  logic [15:0] ms_data;
  bit          m_err;
  bit          m_en;
  logic [3:0]  m_sel;
  logic [15:0] m_out;

  function automatic bit m_stall();
    return ms_v || (wb_src >= 2'd2 && mq_reg.size() == DEPTH);
  endfunction

  function automatic logic [15:0] m_mask();
    logic [15:0] m;
    m = '0;
    foreach (mq_reg[i]) m = m | (16'd1 << mq_reg[i]);
    return m;
  endfunction

  function automatic void m_pick(output bit acc, output bit rok, output bit bad,
                                 output bit wv, output logic [3:0] wr, output logic [15:0] wd);
    acc = wb_valid && !m_stall();
    rok = 1'b0;
    if (mq_reg.size() > 0 && !(mem_rsp_valid && port_rsp_valid))
      rok = mq_port[0] ? port_rsp_valid : mem_rsp_valid;
    bad = (mem_rsp_valid || port_rsp_valid) && !rok;
    wv = 1'b0; wr = '0; wd = '0;
    if (rok) begin
      wv = 1'b1; wr = mq_reg[0]; wd = mem_rsp_valid ? mem_rsp_data : port_rsp_data;
    end else if (ms_v) begin
      wv = 1'b1; wr = ms_reg; wd = ms_data;
    end else if (acc && wb_src < 2'd2) begin
      wv = 1'b1; wr = wb_reg; wd = wb_data;
    end
  endfunction

  // Advance one clock. The call is made with inputs already driven at the
  // negedge, and the task returns at the next negedge.
  task automatic tick();
    bit acc, rok, bad, wv;
    logic [3:0] wr;
    logic [15:0] wd;
    m_pick(acc, rok, bad, wv, wr, wd);
    @(posedge clk);
    if (rst) begin
      mq_reg.delete(); mq_port.delete();
      ms_v = 0; m_err = 0; m_en = 0; m_sel = '0; m_out = '0;
    end else begin
      m_en = wv && (wr != 4'd0);
      if (wv) begin m_sel = wr; m_out = wd; end
      if (bad) m_err = 1;
      if (rok) begin void'(mq_reg.pop_front()); void'(mq_port.pop_front()); end
      if (acc && wb_src >= 2'd2) begin mq_reg.push_back(wb_reg); mq_port.push_back(wb_src == 2'd3); end
      if (acc && wb_src < 2'd2 && rok) begin ms_v = 1; ms_reg = wb_reg; ms_data = wb_data; end
      else if (ms_v && !rok) ms_v = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 0; wb_src = '0; wb_reg = '0; wb_data = '0;
    mem_rsp_valid = 0; mem_rsp_data = '0; port_rsp_valid = 0; port_rsp_data = '0;
    #1;
  endtask

  task automatic req(input logic [1:0] src, input logic [3:0] r, input logic [15:0] d);
    wb_valid = 1; wb_src = src; wb_reg = r; wb_data = d;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; tick(); tick(); rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out, rsp_err, pending_mask, wb_stall} !== 39'd0) begin
      failures++;
      $display("FAIL reset_state got en=%0b sel=%0h out=%0h err=%0b mask=%0h stall=%0b exp all 0",
               reg_wr_en, reg_wr_sel, reg_out, rsp_err, pending_mask, wb_stall);
    end
  endtask

  task automatic test_alu();
    req(2'd0, 4'd3, 16'h1234);
    checks++;
    if (wb_stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", wb_stall); end
`ifdef SLURM16_WB_BYPASS_EN
    checks++;
    if ({bypass_valid, bypass_sel, bypass_data} !== {1'b1, 4'd3, 16'h1234}) begin
      failures++; $display("FAIL alu_bypass got=%0b/%0h/%0h exp=1/3/1234", bypass_valid, bypass_sel, bypass_data);
    end
`endif
    tick(); idle();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out} !== {1'b1, 4'd3, 16'h1234}) begin
      failures++; $display("FAIL alu_write got=%0b/%0h/%0h exp=1/3/1234", reg_wr_en, reg_wr_sel, reg_out);
    end
    tick();
    checks++;
    if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL alu_idle_en got=%0b exp=0", reg_wr_en); end
  endtask

  task automatic test_load();
    req(2'd2, 4'd5, 16'hDEAD);
    checks++;
    if (pending_mask !== 16'h0) begin failures++; $display("FAIL load_mask_c0 got=%0h exp=0", pending_mask); end
    tick(); idle();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (pending_mask !== 16'h0020 || reg_wr_en !== 1'b0) begin
        failures++; $display("FAIL load_pending c%0d got mask=%0h en=%0b exp mask=0020 en=0", c, pending_mask, reg_wr_en);
      end
      tick();
    end
    mem_rsp_valid = 1; mem_rsp_data = 16'hBEEF; #1;
    tick(); idle();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out, pending_mask, rsp_err} !== {1'b1, 4'd5, 16'hBEEF, 16'h0, 1'b0}) begin
      failures++; $display("FAIL load_write got=%0b/%0h/%0h mask=%0h err=%0b exp=1/5/beef mask=0 err=0",
                           reg_wr_en, reg_wr_sel, reg_out, pending_mask, rsp_err);
    end
  endtask

  task automatic test_collision();
    req(2'd2, 4'd9, 16'h0); tick(); idle();
    req(2'd0, 4'd2, 16'h0007);
    mem_rsp_valid = 1; mem_rsp_data = 16'hA5A5; #1;
    checks++;
    if (wb_stall !== 1'b0) begin failures++; $display("FAIL coll_stall0 got=%0b exp=0", wb_stall); end
    tick(); idle();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out} !== {1'b1, 4'd9, 16'hA5A5}) begin
      failures++; $display("FAIL coll_load_first got=%0b/%0h/%0h exp=1/9/a5a5", reg_wr_en, reg_wr_sel, reg_out);
    end
    req(2'd1, 4'd7, 16'h0055);
    checks++;
    if (wb_stall !== 1'b1) begin failures++; $display("FAIL coll_stall1 got=%0b exp=1", wb_stall); end
    tick();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out} !== {1'b1, 4'd2, 16'h0007}) begin
      failures++; $display("FAIL coll_skid_drain got=%0b/%0h/%0h exp=1/2/7", reg_wr_en, reg_wr_sel, reg_out);
    end
    checks++;
    if (wb_stall !== 1'b0) begin failures++; $display("FAIL coll_stall2 got=%0b exp=0", wb_stall); end
    tick(); idle();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out} !== {1'b1, 4'd7, 16'h0055}) begin
      failures++; $display("FAIL coll_link got=%0b/%0h/%0h exp=1/7/55", reg_wr_en, reg_wr_sel, reg_out);
    end
    tick();
  endtask

  task automatic test_queue_full();
    do_reset();
    req(2'd2, 4'd1, 16'h0); tick();
    req(2'd3, 4'd4, 16'h0); tick();
    req(2'd2, 4'd6, 16'h0);
    port_rsp_valid = 1; port_rsp_data = 16'h9999; #1;
    checks++;
    if (wb_stall !== 1'b1 || pending_mask !== 16'h0012) begin
      failures++; $display("FAIL qfull_stall got stall=%0b mask=%0h exp stall=1 mask=0012", wb_stall, pending_mask);
    end
    tick();
    port_rsp_valid = 0; #1;
    checks++;
    if ({rsp_err, reg_wr_en, pending_mask} !== {1'b1, 1'b0, 16'h0012}) begin
      failures++; $display("FAIL type_mismatch got err=%0b en=%0b mask=%0h exp err=1 en=0 mask=0012", rsp_err, reg_wr_en, pending_mask);
    end
    mem_rsp_valid = 1; mem_rsp_data = 16'h1111; #1;
    checks++;
    if (wb_stall !== 1'b1) begin failures++; $display("FAIL qfull_no_credit got=%0b exp=1", wb_stall); end
    tick();
    mem_rsp_valid = 0; #1;
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out, pending_mask, wb_stall} !== {1'b1, 4'd1, 16'h1111, 16'h0010, 1'b0}) begin
      failures++; $display("FAIL qfull_pop got=%0b/%0h/%0h mask=%0h stall=%0b exp=1/1/1111 mask=0010 stall=0",
                           reg_wr_en, reg_wr_sel, reg_out, pending_mask, wb_stall);
    end
    tick(); idle();
    checks++;
    if (pending_mask !== 16'h0050) begin failures++; $display("FAIL qfull_mask got=%0h exp=0050", pending_mask); end
    port_rsp_valid = 1; port_rsp_data = 16'h4444; #1; tick(); idle();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out} !== {1'b1, 4'd4, 16'h4444}) begin
      failures++; $display("FAIL port_write got=%0b/%0h/%0h exp=1/4/4444", reg_wr_en, reg_wr_sel, reg_out);
    end
    mem_rsp_valid = 1; mem_rsp_data = 16'h6666; #1; tick(); idle();
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out, pending_mask} !== {1'b1, 4'd6, 16'h6666, 16'h0}) begin
      failures++; $display("FAIL qdrain got=%0b/%0h/%0h mask=%0h exp=1/6/6666 mask=0", reg_wr_en, reg_wr_sel, reg_out, pending_mask);
    end
  endtask

  task automatic test_r0_and_err();
    do_reset();
    req(2'd0, 4'd0, 16'hFFFF);
    checks++;
    if (bypass_valid !== 1'b0) begin failures++; $display("FAIL r0_bypass got=%0b exp=0", bypass_valid); end
    tick(); idle();
    checks++;
    if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL r0_write got=%0b exp=0", reg_wr_en); end
    checks++;
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL err_pre got=%0b exp=0", rsp_err); end
    mem_rsp_valid = 1; mem_rsp_data = 16'h1; #1; tick(); idle();
    checks++;
    if ({rsp_err, reg_wr_en} !== 2'b10) begin failures++; $display("FAIL empty_rsp got err=%0b en=%0b exp err=1 en=0", rsp_err, reg_wr_en); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req(2'd0, 4'd11, 16'hABCD); tick();
    req(2'd2, 4'd3, 16'h0); tick();
    req(2'd3, 4'd8, 16'h0); tick(); idle();
    checks++;
    if (pending_mask !== 16'h0108) begin failures++; $display("FAIL mid_mask got=%0h exp=0108", pending_mask); end
    rst = 1; tick(); rst = 0; #1;
    checks++;
    if ({reg_wr_en, reg_wr_sel, reg_out, pending_mask, rsp_err} !== 38'd0) begin
      failures++; $display("FAIL mid_reset got=%0b/%0h/%0h mask=%0h err=%0b exp all 0",
                           reg_wr_en, reg_wr_sel, reg_out, pending_mask, rsp_err);
    end
    mem_rsp_valid = 1; mem_rsp_data = 16'h3333; #1; tick(); idle();
    checks++;
    if ({rsp_err, reg_wr_en} !== 2'b10) begin failures++; $display("FAIL late_rsp got err=%0b en=%0b exp err=1 en=0", rsp_err, reg_wr_en); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      wb_valid = ($urandom_range(0, 2) != 0);
      wb_src = 2'($urandom_range(0, 3));
      wb_reg = 4'($urandom_range(0, 15));
      wb_data = 16'($urandom);
      mem_rsp_valid = 0; port_rsp_valid = 0;
      mem_rsp_data = 16'($urandom); port_rsp_data = 16'($urandom);
      if (mq_reg.size() > 0 && $urandom_range(0, 1) == 1) begin
        if (mq_port[0]) port_rsp_valid = 1; else mem_rsp_valid = 1;
      end else if ($urandom_range(0, 39) == 0) begin
        mem_rsp_valid = 1; port_rsp_valid = ($urandom_range(0, 1) == 1);
      end
      #1;
      if (!rst) begin
        bit acc, rok, bad, wv;
        logic [3:0] wr;
        logic [15:0] wd;
        m_pick(acc, rok, bad, wv, wr, wd);
        checks++;
        if (wb_stall !== m_stall()) begin failures++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, wb_stall, m_stall()); end
`ifdef SLURM16_WB_BYPASS_EN
        checks++;
        if (bypass_valid !== (wv && wr != 4'd0) || (wv && (bypass_sel !== wr || bypass_data !== wd))) begin
          failures++; $display("FAIL rnd_bypass n=%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", n, bypass_valid, bypass_sel, bypass_data, wv && wr != 4'd0, wr, wd);
        end
`else
        checks++;
        if ({bypass_valid, bypass_sel, bypass_data} !== 21'd0) begin failures++; $display("FAIL rnd_bypass_tied n=%0d got=%0b", n, bypass_valid); end
`endif
      end
      tick();
      checks++;
      if ({reg_wr_en, reg_wr_sel, reg_out} !== {m_en, m_sel, m_out}) begin
        failures++; $display("FAIL rnd_write n=%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", n, reg_wr_en, reg_wr_sel, reg_out, m_en, m_sel, m_out);
      end
      checks++;
      if (pending_mask !== m_mask() || rsp_err !== m_err) begin
        failures++; $display("FAIL rnd_state n=%0d got mask=%0h err=%0b exp mask=%0h err=%0b", n, pending_mask, rsp_err, m_mask(), m_err);
      end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_collision();
    test_queue_full();
    test_r0_and_err();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
